// File: rtl/code_checker.sv
// Combination-lock code checker: compares a keyed digit sequence against a stored code,
// then drives unlock / fail / lockout status with consecutive-failure tracking.
module code_checker #(
  parameter int unsigned                 DIGITS         = 4,
  parameter int unsigned                 DIGIT_W        = 4,
  parameter logic [DIGITS*DIGIT_W-1:0]   CODE           = 16'h1234,
  parameter int unsigned                 MAX_FAILS      = 3,
  parameter int unsigned                 UNLOCK_CYCLES  = 50_000_000,
  parameter int unsigned                 LOCKOUT_CYCLES = 250_000_000
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               entry_i,
  input  logic [DIGIT_W-1:0] digit_i,
  input  logic               entering_last_digit_i,
  output logic               unlock_o,
  output logic               fail_o,
  output logic               locked_out_o,
  output logic [2:0]         fail_count_o
);

  localparam int unsigned IDX_W   = $clog2(DIGITS + 1);
  localparam int unsigned MAX_CYC = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int unsigned TMR_W   = $clog2(MAX_CYC + 1);

  localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(DIGITS);
  localparam logic [2:0]       FAIL_MAX = 3'(MAX_FAILS);
  localparam logic [TMR_W-1:0] T_UNLOCK = TMR_W'(UNLOCK_CYCLES);
  localparam logic [TMR_W-1:0] T_LOCK   = TMR_W'(LOCKOUT_CYCLES);

  typedef enum logic [1:0] {COLLECT, EVALUATE, UNLOCKED, LOCKOUT} state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic               r_mismatch;
  logic [TMR_W-1:0]   r_timer;
  logic [2:0]         r_fail_cnt;
  logic               r_unlock;
  logic               r_fail;
  logic               r_locked;

  logic [DIGIT_W-1:0] w_exp;
  logic               w_full;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic               w_mis_nxt;
  logic [2:0]         w_cnt_inc;

  // Expected digit for the current index; first entered digit is the MS digit of CODE.
  always_comb begin
    w_exp = '0;
    for (int k = 0; k < int'(DIGITS); k++)
      if (r_idx == IDX_W'(k))
        w_exp = CODE[(int'(DIGITS) - 1 - k) * int'(DIGIT_W) +: DIGIT_W];
  end

  assign w_full    = (r_idx == IDX_FULL);
  assign w_idx_nxt = w_full ? r_idx : r_idx + IDX_W'(1);
  assign w_mis_nxt = r_mismatch | w_full | (digit_i != w_exp);
  assign w_cnt_inc = (r_fail_cnt == FAIL_MAX) ? r_fail_cnt : r_fail_cnt + 3'd1;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= COLLECT;
      r_idx      <= '0;
      r_mismatch <= 1'b0;
      r_timer    <= '0;
      r_fail_cnt <= '0;
      r_unlock   <= 1'b0;
      r_fail     <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      // Status outputs trail the state by one cycle, giving the 2-cycle rise after the last strobe.
      r_fail   <= 1'b0;
      r_unlock <= (r_state == UNLOCKED);
      r_locked <= (r_state == LOCKOUT);
      case (r_state)
        COLLECT: begin
          if (entry_i) begin
            r_idx      <= w_idx_nxt;
            r_mismatch <= w_mis_nxt | (entering_last_digit_i && (w_idx_nxt != IDX_FULL));
            if (entering_last_digit_i) r_state <= EVALUATE;
          end
        end
        EVALUATE: begin
          r_idx      <= '0;
          r_mismatch <= 1'b0;
          if (!r_mismatch) begin
            r_fail_cnt <= '0;
            r_timer    <= T_UNLOCK;
            r_state    <= UNLOCKED;
          end else begin
            r_fail     <= 1'b1;
            r_fail_cnt <= w_cnt_inc;
            if (w_cnt_inc == FAIL_MAX) begin
              r_timer <= T_LOCK;
              r_state <= LOCKOUT;
            end else begin
              r_state <= COLLECT;
            end
          end
        end
        UNLOCKED, LOCKOUT: begin
          if (r_timer <= TMR_W'(1)) begin
            r_timer <= '0;
            r_state <= COLLECT;
            if (r_state == LOCKOUT) r_fail_cnt <= '0;
          end else begin
            r_timer <= r_timer - TMR_W'(1);
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

  assign unlock_o     = r_unlock;
  assign fail_o       = r_fail;
  assign locked_out_o = r_locked;
  assign fail_count_o = r_fail_cnt;

  a_excl: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0({unlock_o, fail_o, locked_out_o}));

endmodule

// File: tb/tb_code_checker.sv
// Bench for code_checker: directed digit sequences, a timeline model of expected status
// per clock, and a few literal spot checks at hand-computed points.
module tb_code_checker;
  localparam int U  = 4;
  localparam int L  = 8;
  localparam int MF = 3;
  localparam int N  = 1024;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       entry = 1'b0;
  logic       last = 1'b0;
  logic [3:0] digit = 4'h0;
  logic       unl, fl, lk;
  logic [2:0] cnt;

  always #5 clk = ~clk;

  code_checker #(
    .DIGITS(4), .DIGIT_W(4), .CODE(16'h1234), .MAX_FAILS(MF),
    .UNLOCK_CYCLES(U), .LOCKOUT_CYCLES(L)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .entry_i(entry), .digit_i(digit),
    .entering_last_digit_i(last), .unlock_o(unl), .fail_o(fl),
    .locked_out_o(lk), .fail_count_o(cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // exp_*[e] = expected output value right after clock edge e
  bit       exp_unl[N];
  bit       exp_fail[N];
  bit       exp_lock[N];
  bit [2:0] exp_cnt[N];
  logic [3:0] code_d[4] = '{4'h1, 4'h2, 4'h3, 4'h4};

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, got, exp);
    end
  endtask

  function automatic void fill_cnt(input int from, input int v);
    for (int i = from; i < N; i++) exp_cnt[i] = 3'(v);
  endfunction

  // Model: collect accepted digits, judge the whole sequence on the last one, schedule the outcome.
  initial begin : model
    int e, accept_from, m_cnt;
    bit ok;
    logic [3:0] q[$];
    accept_from = 0;
    m_cnt = 0;
    forever begin
      @(posedge clk);
      cyc++;
      e = cyc;
      if (e < N - 16) begin
        if (!rst_n) begin
          for (int i = e; i < N; i++) begin
            exp_unl[i] = 0; exp_fail[i] = 0; exp_lock[i] = 0; exp_cnt[i] = 0;
          end
          q.delete();
          m_cnt = 0;
          accept_from = e + 1;
        end else if (entry && e >= accept_from) begin
          q.push_back(digit);
          if (last) begin
            ok = (q.size() == 4);
            if (ok) for (int k = 0; k < 4; k++) if (q[k] != code_d[k]) ok = 0;
            q.delete();
            if (ok) begin
              m_cnt = 0;
              fill_cnt(e + 1, 0);
              for (int k = 2; k <= U + 1; k++) exp_unl[e + k] = 1;
              accept_from = e + U + 2;
            end else begin
              if (m_cnt < MF) m_cnt++;
              exp_fail[e + 1] = 1;
              fill_cnt(e + 1, m_cnt);
              if (m_cnt == MF) begin
                for (int k = 2; k <= L + 1; k++) exp_lock[e + k] = 1;
                fill_cnt(e + L + 1, 0);
                m_cnt = 0;
                accept_from = e + L + 2;
              end else begin
                accept_from = e + 2;
              end
            end
          end
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (cyc >= 1 && cyc < N - 16) begin
        chk("unlock_o", {31'd0, unl}, {31'd0, exp_unl[cyc]});
        chk("fail_o", {31'd0, fl}, {31'd0, exp_fail[cyc]});
        chk("locked_out_o", {31'd0, lk}, {31'd0, exp_lock[cyc]});
        chk("fail_count_o", {29'd0, cnt}, {29'd0, exp_cnt[cyc]});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [3:0] d, input logic l);
    entry = 1'b1; digit = d; last = l;
    @(negedge clk);
    entry = 1'b0; last = 1'b0;
    @(negedge clk);
  endtask

  // Digits given MS-first in a hex word; the flag rides on the n-th strobe.
  task automatic enter(input int n, input logic [31:0] ds);
    logic [31:0] w;
    w = ds;
    for (int k = 0; k < n; k++) strobe(w[4*(n-1-k) +: 4], k == n - 1);
  endtask

  initial begin : drive
    rst_n = 1'b0;
    idle(3);
    chk("rst_unlock", {31'd0, unl}, 32'd0);
    chk("rst_fail", {31'd0, fl}, 32'd0);
    chk("rst_locked", {31'd0, lk}, 32'd0);
    chk("rst_count", {29'd0, cnt}, 32'd0);
    rst_n = 1'b1;

    enter(4, 32'h1234);
    chk("ok_no_fail", {31'd0, fl}, 32'd0);
    chk("ok_unlock_not_yet", {31'd0, unl}, 32'd0);
    idle(1); chk("ok_unlock_rise", {31'd0, unl}, 32'd1);
    chk("ok_count", {29'd0, cnt}, 32'd0);
    idle(3); chk("ok_unlock_last", {31'd0, unl}, 32'd1);
    idle(1); chk("ok_unlock_fall", {31'd0, unl}, 32'd0);
    idle(2);

    enter(4, 32'h1235);
    chk("bad_fail_pulse", {31'd0, fl}, 32'd1);
    chk("bad_count1", {29'd0, cnt}, 32'd1);
    idle(1); chk("bad_fail_end", {31'd0, fl}, 32'd0);
    chk("bad_no_unlock", {31'd0, unl}, 32'd0);
    idle(2);

    enter(4, 32'h1235);
    chk("two_fails", {29'd0, cnt}, 32'd2);
    idle(2);
    enter(4, 32'h1234);
    chk("good_clears_count", {29'd0, cnt}, 32'd0);
    idle(1); chk("good_after_fails", {31'd0, unl}, 32'd1);
    idle(6);

    enter(4, 32'h1235); chk("lk_count1", {29'd0, cnt}, 32'd1);
    enter(4, 32'h1235); chk("lk_count2", {29'd0, cnt}, 32'd2);
    enter(4, 32'h1235); chk("lk_count3", {29'd0, cnt}, 32'd3);
    idle(1); chk("lk_active", {31'd0, lk}, 32'd1);
    enter(4, 32'h1234);
    chk("lk_over", {31'd0, lk}, 32'd0);
    chk("lk_count_clr", {29'd0, cnt}, 32'd0);
    chk("lk_ignored", {31'd0, unl}, 32'd0);
    enter(4, 32'h1234);
    idle(1); chk("lk_then_unlock", {31'd0, unl}, 32'd1);
    idle(6);

    enter(3, 32'h123);
    chk("short_fail", {31'd0, fl}, 32'd1);
    idle(2);
    enter(5, 32'h12345);
    chk("long_fail", {31'd0, fl}, 32'd1);
    chk("long_count", {29'd0, cnt}, 32'd2);
    idle(2);

    enter(4, 32'h1234);
    idle(2); chk("mid_unlock", {31'd0, unl}, 32'd1);
    rst_n = 1'b0;
    idle(1); chk("rst_unlock_clr", {31'd0, unl}, 32'd0);
    rst_n = 1'b1;
    idle(1);
    enter(4, 32'h1235);
    enter(4, 32'h1235);
    enter(4, 32'h1235);
    idle(3); chk("mid_lockout", {31'd0, lk}, 32'd1);
    rst_n = 1'b0;
    idle(1); chk("rst_lock_clr", {31'd0, lk}, 32'd0);
    chk("rst_cnt_clr", {29'd0, cnt}, 32'd0);
    rst_n = 1'b1;
    idle(1);
    enter(4, 32'h1234);
    idle(1); chk("post_rst_unlock", {31'd0, unl}, 32'd1);
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
